// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     any
);

  localparam int PW = $clog2(N_REQ);

  int          j;
  logic [PW-1:0] jw;

  assign any = |req;

  // Scan from the farthest candidate down so the nearest one to ptr wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    jw  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      jw = PW'(j);
      if (req[jw]) begin
        gnt     = '0;
        gnt[jw] = 1'b1;
        idx     = jw;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer among N_REQ byte streams, round-robin per packet.
// Optional mid-packet stall release: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [UART_DW*N_REQ-1:0]   req_data_i,
  input  logic [N_REQ-1:0]           req_last_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic [N_REQ-1:0]           grant_o,
  output logic                       busy_o,
  output logic [UART_DW-1:0]         tx_din_o,
  output logic                       tx_start_o,
  input  logic                       tx_done_tick_i,
  output logic                       timeout_o
);

  // state   | meaning
  // S_IDLE  | no owner; arbitrate among valid requesters
  // S_FETCH | owner granted; waiting for its next byte
  // S_START | byte latched; start pulse to the serializer
  // S_WAIT  | byte in flight; waiting for the done tick

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n
    $error("uart_tx_arbiter: N_REQ must be 2..16");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_to
    $error("uart_tx_arbiter: TIMEOUT_CYC must be at least 2");
  end

  arb_state_t         state_q, state_d;
  logic [N_REQ-1:0]   grant_q;
  logic [PW-1:0]      gidx_q, ptr_q, ptr_next;
  logic               last_q;
  logic [UART_DW-1:0] din_q;
  logic [N_REQ-1:0]   pick_gnt;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;
  logic               do_grant, do_hs, do_release, stall_to;
  logic [UART_DW-1:0] req_byte [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_byte
    assign req_byte[k] = req_data_i[UART_DW*k +: UART_DW];
  end

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (req_valid_i),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The requester that just finished gets lowest priority next time.
  assign ptr_next = (gidx_q == PW'(N_REQ - 1)) ? '0 : gidx_q + PW'(1);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] stall_q;

  assign stall_to = (state_q == S_FETCH) && (stall_q == CW'(TIMEOUT_CYC));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (state_q != S_FETCH || req_valid_i[gidx_q]) begin
      stall_q <= '0;
    end else if (stall_q != CW'(TIMEOUT_CYC)) begin
      stall_q <= stall_q + CW'(1);
    end
  end
`else
  assign stall_to = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    do_grant    = 1'b0;
    do_hs       = 1'b0;
    do_release  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          do_grant = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (stall_to) begin
          do_release = 1'b1;
          state_d    = S_IDLE;
        end else begin
          req_ready_o[gidx_q] = req_valid_i[gidx_q];
          if (req_valid_i[gidx_q]) begin
            do_hs   = 1'b1;
            state_d = S_START;
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (tx_done_tick_i) begin
          if (last_q) begin
            do_release = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      last_q  <= 1'b0;
      din_q   <= '0;
    end else begin
      if (do_grant) begin
        grant_q <= pick_gnt;
        gidx_q  <= pick_idx;
      end
      if (do_hs) begin
        din_q  <= req_byte[gidx_q];
        last_q <= req_last_i[gidx_q];
      end
      if (do_release) begin
        grant_q <= '0;
        ptr_q   <= ptr_next;
      end
    end
  end

  assign grant_o    = grant_q;
  assign busy_o     = (state_q != S_IDLE);
  assign tx_start_o = (state_q == S_START);
  assign tx_din_o   = din_q;
  assign timeout_o  = stall_to;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, serializer stand-in and a transaction-level model.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int TCYC = 16;
  localparam int QD   = 256;
`ifdef UART_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic [N-1:0]   req_valid_i = '0;
  logic [8*N-1:0] req_data_i = '0;
  logic [N-1:0]   req_last_i = '0;
  logic [N-1:0]   req_ready_o;
  logic [N-1:0]   grant_o;
  logic           busy_o;
  logic [7:0]     tx_din_o;
  logic           tx_start_o;
  logic           tx_done_tick_i = 1'b0;
  logic           timeout_o;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TCYC)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_data_i     (req_data_i),
    .req_last_i     (req_last_i),
    .req_ready_o    (req_ready_o),
    .grant_o        (grant_o),
    .busy_o         (busy_o),
    .tx_din_o       (tx_din_o),
    .tx_start_o     (tx_start_o),
    .tx_done_tick_i (tx_done_tick_i),
    .timeout_o      (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // requester byte queues: {last, data}
  logic [8:0] mem [N][QD];
  int         head [N];
  int         tail [N];
  logic [N-1:0] hs = '0;
  logic [N-1:0] hold_low = '0;
  bit gap_en = 0, spur_en = 0, lat_rand = 0;
  int lat = 40;
  bit ser_pending = 0;
  int done_at = 0;

  // reference model
  int         m_owner = -1, m_ptr = 0, m_stall = 0, m_hs_cyc = 0;
  bit         m_holding = 0;
  logic [8:0] m_byte = '0;

  // event logs
  int         glog[$];
  int         slog_cyc[$];
  logic [7:0] slog_din[$];
  logic [N-1:0] slog_gnt[$];
  int         dlog[$];
  int         tolog[$];
  int         n_starts = 0, busy_fall = -1, vrise = -1;
  logic       prev_busy = 1'b0;
  logic [N-1:0] prev_grant = '0, prev_valid = '0;

  bit           fetching, fire, e_start;
  logic [N-1:0] e_grant, e_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit vbit(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  function automatic int rr_model(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (p + i) % N;
      if (vbit(v, j)) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_stall = 0; m_holding = 0;
  endtask

  task automatic push(input int k, input logic [7:0] d, input bit last);
    if (tail[k] < QD) begin
      mem[k][tail[k]] = {last, d};
      tail[k]++;
    end
  endtask

  task automatic flush();
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    ser_pending = 0;
    hold_low = '0;
  endtask

  function automatic bit queues_empty();
    for (int k = 0; k < N; k++) if (head[k] != tail[k]) return 0;
    return 1;
  endfunction

  // compare process: outputs against the model every cycle, then advance the model
  always @(negedge clk_i) begin
    if (rst_i) begin
      model_reset();
      hs = '0;
      chk("rst_grant", 32'(grant_o), 0);
      chk("rst_ready", 32'(req_ready_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_start", 32'(tx_start_o), 0);
      chk("rst_timeout", 32'(timeout_o), 0);
    end else begin
      fetching = (m_owner >= 0) && !m_holding;
      fire     = TO_EN && fetching && (m_stall == TCYC);
      e_grant  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e_ready  = '0;
      if (fetching && !fire && vbit(req_valid_i, m_owner)) e_ready = N'(1) << m_owner;
      e_start  = m_holding && (cyc == m_hs_cyc + 1);

      chk("grant", 32'(grant_o), 32'(e_grant));
      chk("ready", 32'(req_ready_o), 32'(e_ready));
      chk("busy", 32'(busy_o), 32'(m_owner >= 0));
      chk("start", 32'(tx_start_o), 32'(e_start));
      chk("timeout", 32'(timeout_o), 32'(fire));
      if (e_start) chk("din", 32'(tx_din_o), 32'(m_byte[7:0]));

      if (tx_start_o) begin
        slog_cyc.push_back(cyc);
        slog_din.push_back(tx_din_o);
        slog_gnt.push_back(grant_o);
        n_starts++;
        ser_pending = 1;
        done_at = cyc + (lat_rand ? int'($urandom_range(1, 6)) : lat);
      end
      if (timeout_o) tolog.push_back(cyc);
      if (grant_o != '0 && prev_grant == '0)
        for (int k = 0; k < N; k++) if (vbit(grant_o, k)) glog.push_back(k);
      if (prev_busy && !busy_o) busy_fall = cyc;
      if (req_valid_i != '0 && prev_valid == '0) vrise = cyc;
      hs = req_valid_i & req_ready_o;

      if (m_owner < 0) begin
        if (req_valid_i != '0) begin
          m_owner = rr_model(req_valid_i, m_ptr);
          m_stall = 0;
        end
      end else if (!m_holding) begin
        if (fire) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
          m_stall = 0;
        end else if (vbit(req_valid_i, m_owner)) begin
          m_holding = 1;
          m_hs_cyc  = cyc;
          m_byte    = mem[m_owner][head[m_owner]];
          m_stall   = 0;
        end else if (m_stall < TCYC) begin
          m_stall++;
        end
      end else if (cyc > m_hs_cyc + 1 && tx_done_tick_i) begin
        m_holding = 0;
        if (m_byte[8]) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end
    prev_busy  = busy_o;
    prev_grant = grant_o;
    prev_valid = req_valid_i;
  end

  // requester and serializer driver
  initial begin : driver
    forever begin
      @(posedge clk_i);
      cyc++;
      #1;
      for (int k = 0; k < N; k++) if (hs[k]) head[k]++;
      tx_done_tick_i = 1'b0;
      if (ser_pending && cyc == done_at) begin
        tx_done_tick_i = 1'b1;
        ser_pending = 0;
        dlog.push_back(cyc);
      end else if (spur_en && !ser_pending && $urandom_range(0, 5) == 0) begin
        tx_done_tick_i = 1'b1;
      end
      for (int k = 0; k < N; k++) begin
        if (head[k] < tail[k] && !hold_low[k] && !(gap_en && $urandom_range(0, 3) == 0)) begin
          req_valid_i[k] = 1'b1;
          req_data_i[8*k +: 8] = mem[k][head[k]][7:0];
          req_last_i[k] = mem[k][head[k]][8];
        end else begin
          req_valid_i[k] = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle(input string name, input int budget);
    int t;
    bit ok;
    t = 0;
    ok = 0;
    while (!ok && t < budget) begin
      @(negedge clk_i);
      #1;
      ok = queues_empty() && !busy_o && !ser_pending && req_valid_i == '0;
      t++;
    end
    chk(name, 32'(ok), 1);
  endtask

  task automatic wait_start(input string name, input int budget);
    int t;
    int n0;
    t = 0;
    n0 = n_starts;
    while (n_starts == n0 && t < budget) begin
      @(negedge clk_i);
      #1;
      t++;
    end
    chk(name, 32'(n_starts > n0), 1);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    #2 flush();
    @(posedge clk_i);
    #2 rst_i = 1'b0;
  endtask

  function automatic int gl(input int i);
    return (i < glog.size()) ? glog[i] : -1;
  endfunction

  logic [7:0] t1_exp [3] = '{8'hA5, 8'h3C, 8'h81};
  int s0, sidx, nb, tot;

  initial begin : main
    flush();
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_din_lit", 32'(tx_din_o), 32'h00);
    chk("rst_grant_lit", 32'(grant_o), 0);
    chk("rst_busy_lit", 32'(busy_o), 0);
    rst_i = 1'b0;

    // one 3-byte packet from requester 2, 40-cycle serializer
    slog_cyc.delete(); slog_din.delete(); slog_gnt.delete(); dlog.delete();
    push(2, 8'hA5, 0); push(2, 8'h3C, 0); push(2, 8'h81, 1);
    wait_idle("t1_idle", 400);
    chk("t1_nstart", 32'(slog_cyc.size()), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1_din%0d", i), (i < slog_din.size()) ? 32'(slog_din[i]) : 'x, 32'(t1_exp[i]));
      chk($sformatf("t1_gnt%0d", i), (i < slog_gnt.size()) ? 32'(slog_gnt[i]) : 'x, 32'b0100);
    end
    if (slog_cyc.size() == 3 && dlog.size() == 3) begin
      chk("t1_first_lat", 32'(slog_cyc[0] - vrise), 2);
      chk("t1_gap_b2", 32'(slog_cyc[1] - slog_cyc[0]), 42);
      chk("t1_gap_b3", 32'(slog_cyc[2] - slog_cyc[1]), 42);
      chk("t1_busy_fall", 32'(busy_fall - dlog[2]), 1);
    end else begin
      chk("t1_log_sizes", 32'(dlog.size()), 3);
    end

    // simultaneous single-byte packets from 0, 1, 3; requester 0 re-requests
    do_reset();
    lat = 3; spur_en = 1;
    glog.delete();
    push(0, 8'h11, 1); push(0, 8'h12, 1); push(1, 8'h21, 1); push(3, 8'h41, 1);
    wait_idle("t2_idle", 400);
    chk("t2_ngrant", 32'(glog.size()), 4);
    chk("t2_g0", 32'(gl(0)), 0);
    chk("t2_g1", 32'(gl(1)), 1);
    chk("t2_g2", 32'(gl(2)), 3);
    chk("t2_g3", 32'(gl(3)), 0);

    // requester 0 arrives while requester 1 is mid-packet
    lat = 5;
    glog.delete();
    push(1, 8'h31, 0); push(1, 8'h32, 0); push(1, 8'h33, 1);
    wait_start("t3_start", 100);
    push(0, 8'h09, 1);
    wait_idle("t3_idle", 400);
    chk("t3_ngrant", 32'(glog.size()), 2);
    chk("t3_g0", 32'(gl(0)), 1);
    chk("t3_g1", 32'(gl(1)), 0);

    // reset while a byte is in flight; pointer must restart at 0
    spur_en = 0; lat = 40;
    push(2, 8'h55, 1);
    wait_idle("t5_pre_idle", 200);
    push(2, 8'h56, 0); push(2, 8'h57, 1);
    wait_start("t5_start", 100);
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("t5_async_grant", 32'(grant_o), 0);
    chk("t5_async_start", 32'(tx_start_o), 0);
    chk("t5_async_busy", 32'(busy_o), 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #2 flush();
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    glog.delete();
    lat = 4;
    push(1, 8'h61, 1); push(3, 8'h63, 1);
    wait_idle("t5_idle", 200);
    chk("t5_ngrant", 32'(glog.size()), 2);
    chk("t5_g0", 32'(gl(0)), 1);
    chk("t5_g1", 32'(gl(1)), 3);

    // requester 0 stalls mid-packet while requester 1 waits
    lat = 40;
    glog.delete(); tolog.delete();
    push(0, 8'h71, 0); push(0, 8'h72, 0); push(0, 8'h73, 1);
    wait_start("t6_start", 100);
    sidx = n_starts;
    s0 = slog_cyc[slog_cyc.size() - 1];
    hold_low[0] = 1'b1;
    push(1, 8'h81, 1);
`ifdef UART_ARB_TIMEOUT_EN
    repeat (200) @(negedge clk_i);
    #1;
    chk("t6_ntimeout", 32'(tolog.size()), 1);
    chk("t6_to_cycle", (tolog.size() > 0) ? 32'(tolog[0] - s0) : 'x, 57);
    hold_low[0] = 1'b0;
    wait_idle("t6_idle", 400);
    chk("t6_ngrant", 32'(glog.size()), 3);
    chk("t6_g0", 32'(gl(0)), 0);
    chk("t6_g1", 32'(gl(1)), 1);
    chk("t6_g2", 32'(gl(2)), 0);
`else
    repeat (1000) @(negedge clk_i);
    #1;
    chk("t6_held_grant", 32'(grant_o), 32'b0001);
    chk("t6_no_timeout", 32'(tolog.size()), 0);
    chk("t6_no_extra_start", 32'(n_starts - sidx), 0);
    hold_low[0] = 1'b0;
    wait_idle("t6_idle", 400);
    chk("t6_ngrant", 32'(glog.size()), 2);
    chk("t6_g0", 32'(gl(0)), 0);
    chk("t6_g1", 32'(gl(1)), 1);
`endif

    // randomized traffic with valid gaps, stray done ticks and random latency
    gap_en = 1; spur_en = 1; lat_rand = 1;
    sidx = n_starts;
    tot = 0;
    for (int p = 0; p < 40; p++) begin
      int k;
      k = $urandom_range(0, N - 1);
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) push(k, 8'($urandom), b == nb - 1);
      tot += nb;
    end
    wait_idle("t7_idle", 20000);
    chk("t7_nbytes", 32'(n_starts - sidx), 32'(tot));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 100000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
